// File: rtl/jt12_bus_master.sv
// jt12_bus_master: queues (part, reg, val) writes and replays each one on the
// jt12 CPU bus as an address write followed by a data write. After the data
// write it polls status bit 7 until the chip reports ready.
// Ports: clk, rst_n (async, active low), cen (bus clock enable)
//   cmd_valid/cmd_ready/cmd_part/cmd_reg/cmd_val : command FIFO input
//   flush : drop every queued command that is not yet in flight
//   ym_addr/ym_din/ym_cs_n/ym_wr_n : chip bus, ym_dout : chip status
//   busy, timeout_err (sticky), level : status
module jt12_bus_master #(
  parameter int AW       = 4,
  parameter int STRB     = 2,
  parameter int POLL_MAX = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_part,
  input  logic [7:0]  cmd_reg,
  input  logic [7:0]  cmd_val,
  input  logic        flush,
  output logic [1:0]  ym_addr,
  output logic [7:0]  ym_din,
  output logic        ym_cs_n,
  output logic        ym_wr_n,
  input  logic [7:0]  ym_dout,
  output logic        busy,
  output logic        timeout_err,
  output logic [AW:0] level
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    IDLE, A_STB, A_REL, D_STB, D_REL, P_RD, P_CHK
  } state_t;

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [16:0]   head;
  logic          empty, push, pop;

  state_t        state, nxt;
  logic [3:0]    cnt;
  logic [7:0]    pcnt;
  logic          st_busy;
  logic          h_part;
  logic [7:0]    h_reg, h_val;
  logic          c_part;
  logic [7:0]    c_reg, c_val;
  logic [1:0]    n_addr;
  logic [7:0]    n_din;
  logic          n_cs_n, n_wr_n;
  logic          strb_done, last_poll;
  logic          unused_ok;

  assign empty     = (level == '0);
  assign cmd_ready = ~level[AW];
  assign push      = cmd_valid & ~level[AW] & ~flush;
  assign pop       = cen & (state == IDLE) & (nxt == A_STB);
  assign head      = mem[rptr];
  assign busy      = (state != IDLE) | ~empty;
  assign unused_ok = ^ym_dout[6:0];

  // In IDLE the command being launched is still the FIFO head; it lands
  // in the holding register on the same edge the first strobe starts.
  assign c_part = (state == IDLE) ? head[16]    : h_part;
  assign c_reg  = (state == IDLE) ? head[15:8]  : h_reg;
  assign c_val  = (state == IDLE) ? head[7:0]   : h_val;

  assign strb_done = (cnt == 4'(STRB - 1));
  assign last_poll = (pcnt + 8'd1 == 8'(POLL_MAX));

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cmd_part, cmd_reg, cmd_val};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push & ~pop)
        level <= level + (AW+1)'(1);
      else if (pop & ~push)
        level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pcnt        <= '0;
      st_busy     <= 1'b0;
      h_part      <= 1'b0;
      h_reg       <= '0;
      h_val       <= '0;
      ym_addr     <= '0;
      ym_din      <= '0;
      ym_cs_n     <= 1'b1;
      ym_wr_n     <= 1'b1;
      timeout_err <= 1'b0;
    end else if (cen) begin
      state <= nxt;
      cnt   <= (nxt != state) ? 4'd0 : cnt + 4'd1;
      if (pop) begin
        h_part <= head[16];
        h_reg  <= head[15:8];
        h_val  <= head[7:0];
      end
      if (state == D_REL)
        pcnt <= '0;
      else if (state == P_CHK && nxt == P_RD)
        pcnt <= pcnt + 8'd1;
      if (state == P_RD)
        st_busy <= ym_dout[7];
      if (state == P_CHK && st_busy && last_poll)
        timeout_err <= 1'b1;
      ym_addr <= n_addr;
      ym_din  <= n_din;
      ym_cs_n <= n_cs_n;
      ym_wr_n <= n_wr_n;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (!empty && !flush) nxt = A_STB;
      A_STB: if (strb_done) nxt = A_REL;
      A_REL: nxt = D_STB;
      D_STB: if (strb_done) nxt = D_REL;
      D_REL: nxt = P_RD;
      P_RD:  nxt = P_CHK;
      P_CHK: nxt = (!st_busy || last_poll) ? IDLE : P_RD;
      default: nxt = IDLE;
    endcase
  end

  // Bus values are computed from the next state and registered, so cs_n
  // and wr_n switch on the same edge and never glitch.
  always_comb begin
    n_addr = ym_addr;
    n_din  = ym_din;
    n_cs_n = 1'b1;
    n_wr_n = 1'b1;
    unique case (nxt)
      A_STB: begin
        n_addr = {c_part, 1'b0};
        n_din  = c_reg;
        n_cs_n = 1'b0;
        n_wr_n = 1'b0;
      end
      D_STB: begin
        n_addr = {c_part, 1'b1};
        n_din  = c_val;
        n_cs_n = 1'b0;
        n_wr_n = 1'b0;
      end
      P_RD: begin
        n_addr = 2'b00;
        n_cs_n = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
